// File: rtl/xor_share_arb.sv
// xor_share_arb: round-robin arbiter/sequencer sharing one W-bit XOR unit
// (dp_c = dp_a ^ dp_b, fixed latency LAT) among N requesters.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid[N]          per-requester request valid
//   req_a/req_b[N*W]      operands, requester i at bits [i*W +: W]
//   req_ready[N]          one-hot accept (combinational, IDLE only)
//   dp_a/dp_b[W]          registered operands driven into the shared unit
//   dp_c[W]               result returned by the shared unit
//   rsp_valid/rsp_id/rsp_c  response channel (registered), rsp_ready from consumer
//   busy                  high while a transaction is in flight (WAIT or RESP)
module xor_share_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         req_ready,
    output logic [W-1:0]         dp_a,
    output logic [W-1:0]         dp_b,
    input  logic [W-1:0]         dp_c,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_c,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state, state_n;
    logic [ID_W-1:0]  ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [W-1:0]     dp_a_n, dp_b_n, rsp_c_n;
    logic             rsp_valid_n;
    logic [ID_W-1:0]  rsp_id_n;

    logic [N-1:0]     grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic [W-1:0]     sel_a, sel_b;

    // Round-robin search starting one past the last winner, wrapping at N.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_any && req_valid[ID_W'(idx)]) begin
                grant_any            = 1'b1;
                grant[ID_W'(idx)]    = 1'b1;
                grant_id             = ID_W'(idx);
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Accept is only offered in IDLE and never while reset is applied.
    always_comb begin
        req_ready = '0;
        if ((state == S_IDLE) && !rst) begin
            req_ready = grant;
        end
    end

    // Next-state and datapath-register update logic.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        dp_a_n      = dp_a;
        dp_b_n      = dp_b;
        rsp_valid_n = rsp_valid;
        rsp_id_n    = rsp_id;
        rsp_c_n     = rsp_c;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    dp_a_n   = sel_a;
                    dp_b_n   = sel_b;
                    rsp_id_n = grant_id;
                    ptr_n    = grant_id;
                    cnt_n    = CNT_W'(LAT - 1);
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    rsp_c_n     = dp_c;
                    rsp_valid_n = 1'b1;
                    state_n     = S_RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                // Return to IDLE only; the next grant is evaluated there.
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_n = 1'b0;
                state_n     = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(N - 1);
            cnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            dp_a      <= dp_a_n;
            dp_b      <= dp_b_n;
            rsp_valid <= rsp_valid_n;
            rsp_id    <= rsp_id_n;
            rsp_c     <= rsp_c_n;
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: doc/xor_share_arb.md
# xor_share_arb

Round-robin arbiter and sequencer that shares one W-bit XOR datapath unit (`dp_c = dp_a ^ dp_b`, fixed latency LAT) among N requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the registered operands into the shared unit. After LAT cycles it captures the result and returns it, tagged with the requester index, over a valid/ready response channel. It sits between the requesting blocks and the single instantiated XOR unit, so the unit is never driven by two requesters at once.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..16
- `W`, 8: operand/result width, 1..64
- `LAT`, 1: cycles from operands registered to `dp_c` valid, 1..15 (combinational XOR = 1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  N  per-requester request valid
- `req_a`  in  N*W  operand a; requester i at bits [i*W +: W]
- `req_b`  in  N*W  operand b; same packing
- `req_ready`  out  N  one-hot accept; at most one bit high
- `dp_a`  out  W  registered operand a to shared unit
- `dp_b`  out  W  registered operand b to shared unit
- `dp_c`  in  W  result from shared unit
- `rsp_valid`  out  1  response valid
- `rsp_id`  out  $clog2(N)  index of requester owning response
- `rsp_c`  out  W  captured result
- `rsp_ready`  in  1  response consumer ready
- `busy`  out  1  high in WAIT or RESP

## Operation
- FSM states IDLE, WAIT, RESP; reset state IDLE.
- IDLE: `req_ready` is the combinational one-hot round-robin grant over `req_valid`.
  - Search starts at `ptr+1` mod N and wraps.
  - Transfer happens when `req_valid[i] & req_ready[i]`.
  - On transfer, latch `req_a[i]`/`req_b[i]` into `dp_a`/`dp_b`, set `rsp_id = i`, set `ptr = i`, load `cnt = LAT-1`, and go to WAIT.
  - No valid request: stay in IDLE with `req_ready = 0`.
- WAIT: `req_ready = 0`.
  - If `cnt == 0`: capture `dp_c` into `rsp_c` and go to RESP.
  - Otherwise decrement `cnt`.
- RESP: `rsp_valid = 1`; `rsp_c` and `rsp_id` held stable.
  - On `rsp_ready`: go to IDLE. No new grant is issued in the same cycle.
- `dp_a`/`dp_b` hold their last values between transactions. They change only on transfer.
- `ptr` reset value is N-1, so requester 0 has first priority after reset.
- A requester that drops `req_valid` before being granted loses nothing and is simply skipped.
- `busy` = state != IDLE.
- `cnt` is 4 bits wide. There is no arithmetic on data other than the capture.

## Timing
- Accept in cycle T: `dp_a`/`dp_b` are valid from T+1.
- `dp_c` is sampled at the edge ending cycle T+LAT.
- `rsp_valid` goes high from T+LAT+1.
- With `rsp_ready` tied high, the next accept is possible at T+LAT+2, giving a peak throughput of 1 op per LAT+2 cycles.
- Reset values, async on `rst` assertion: state IDLE, `ptr` N-1, `cnt` 0, `dp_a` 0, `dp_b` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_c` 0, `busy` 0.
- `req_ready` is forced to 0 while `rst` is high.
- Reset during WAIT or RESP aborts the transaction: the response is discarded and never presented, and requesters must re-request.
- Deassertion of `rst` takes effect at the next rising edge. The first grant is possible in the first cycle with `rst` low.
- `rsp_valid` never drops without `rsp_ready` (no retraction). `rsp_c`/`rsp_id` are stable while `rsp_valid & !rsp_ready`.
- `req_valid` changing in the same cycle as the grant decision: the grant follows that cycle's `req_valid` (combinational). Requesters must hold operands stable while `req_valid` is high.

## Test plan
1. **Single request.** N=4, W=8, LAT=1. Requester 2 sends a=8'hA5, b=8'h3C at cycle T. Required: `req_ready` = 4'b0100 at T; `dp_a`=A5 and `dp_b`=3C at T+1; `rsp_valid`, `rsp_id`=2 and `rsp_c`=8'h99 at T+2.
2. **Contention after reset.** All four `req_valid` held high and `rsp_ready`=1. Required: grant order 0,1,2,3,0, one grant every 3 cycles. Each `rsp_c` equals that requester's a^b.
3. **Fairness.** Only requesters 1 and 3 are valid, with `ptr`=1. Required: next grant is 3, then 1. Requester 0 is never granted.
4. **Backpressure.** `rsp_ready`=0 for 5 cycles during RESP. Required: `rsp_valid`, `rsp_id` and `rsp_c` stay constant, `req_ready`=0 throughout, and the next grant comes in the cycle after `rsp_ready`=1 is sampled.
5. **Longer latency.** LAT=3; the bench models `dp_c` = registered a^b with 3-cycle latency. Accept at T gives `rsp_valid` at T+4 with the correct result. Values captured earlier would be wrong, which the check must detect.
6. **Reset mid-operation.** Assert `rst` in WAIT. Required: all outputs immediately take their reset values, no response appears for the aborted op, and after release requester 0 is granted first.
